// File: rtl/dsp48_pkg.sv
// Shared DSP48-style slice definitions: carry-in select codes.
package dsp48_pkg;

    localparam int CIN_SEL_W = 3;

    localparam logic [CIN_SEL_W-1:0] CIN_SEL_CARRYIN   = 3'd0;
    localparam logic [CIN_SEL_W-1:0] CIN_SEL_PCIN      = 3'd1;
    localparam logic [CIN_SEL_W-1:0] CIN_SEL_CASCIN    = 3'd2;
    localparam logic [CIN_SEL_W-1:0] CIN_SEL_PCIN_N    = 3'd3;
    localparam logic [CIN_SEL_W-1:0] CIN_SEL_CASCOUT   = 3'd4;
    localparam logic [CIN_SEL_W-1:0] CIN_SEL_P         = 3'd5;
    localparam logic [CIN_SEL_W-1:0] CIN_SEL_XNOR      = 3'd6;
    localparam logic [CIN_SEL_W-1:0] CIN_SEL_P_N       = 3'd7;

    localparam logic [CIN_SEL_W-1:0] CIN_SEL_RST       = CIN_SEL_CARRYIN;

endpackage

// File: rtl/carry_in_mux_cin_reg.sv
// Optional 1-bit carry pipeline flop: async active-low clear, CE, bypass when REG=0.
module cin_reg #(
    parameter int REG = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ce,
    input  logic d,
    output logic q
);

    generate
        if (REG != 0) begin : g_reg
            logic q_q;
            logic q_d;

            assign q_d = ce ? d : q_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_q <= 1'b0;
                end else begin
                    q_q <= q_d;
                end
            end

            assign q = q_q;
        end else begin : g_byp
            // Clock/reset/enable are intentionally unused in bypass mode.
            logic unused_ok;
            assign unused_ok = ^{clk, rst_n, ce};
            assign q = d;
        end
    endgenerate

endmodule

// File: rtl/carry_in_mux.sv
// Carry-in select stage of a DSP48-style slice: 8:1 carry mux into the post-adder.
// Optional select register enabled by defining CARRYIN_SEL_REG_EN.
module carry_in_mux
    import dsp48_pkg::*;
#(
    parameter int CARRYINREG     = 1,
    parameter int MULTCARRYINREG = 1
) (
    input  logic       clk,
    input  logic       RSTALLCARTYIN,
    input  logic       CECARRYIN,
    input  logic [2:0] carryinsel,
    input  logic       carryin,
    input  logic       MSB_Pcin,
    input  logic       carrycascin,
    input  logic       MSB_Pcin_n,
    input  logic       carrycascout,
    input  logic       MSB_P,
    input  logic       Xnor_A24_B17,
    input  logic       MSB_P_n,
    output logic       CIN
);

    logic                 carryin_q;
    logic                 xnor_q;
    logic [CIN_SEL_W-1:0] sel_q;
    logic                 cin_mux;

    cin_reg #(.REG(CARRYINREG)) u_carryin_reg (
        .clk   (clk),
        .rst_n (RSTALLCARTYIN),
        .ce    (CECARRYIN),
        .d     (carryin),
        .q     (carryin_q)
    );

    cin_reg #(.REG(MULTCARRYINREG)) u_xnor_reg (
        .clk   (clk),
        .rst_n (RSTALLCARTYIN),
        .ce    (CECARRYIN),
        .d     (Xnor_A24_B17),
        .q     (xnor_q)
    );

`ifdef CARRYIN_SEL_REG_EN
    logic [CIN_SEL_W-1:0] sel_d;

    assign sel_d = CECARRYIN ? carryinsel : sel_q;

    always_ff @(posedge clk or negedge RSTALLCARTYIN) begin
        if (!RSTALLCARTYIN) begin
            sel_q <= CIN_SEL_RST;
        end else begin
            sel_q <= sel_d;
        end
    end
`else
    assign sel_q = carryinsel;
`endif

    always_comb begin
        cin_mux = 1'b0;
        unique case (sel_q)
            CIN_SEL_CARRYIN: cin_mux = carryin_q;
            CIN_SEL_PCIN:    cin_mux = MSB_Pcin;
            CIN_SEL_CASCIN:  cin_mux = carrycascin;
            CIN_SEL_PCIN_N:  cin_mux = MSB_Pcin_n;
            CIN_SEL_CASCOUT: cin_mux = carrycascout;
            CIN_SEL_P:       cin_mux = MSB_P;
            CIN_SEL_XNOR:    cin_mux = xnor_q;
            CIN_SEL_P_N:     cin_mux = MSB_P_n;
            default:         cin_mux = 1'b0;
        endcase
    end

    assign CIN = cin_mux;

endmodule

// File: tb/tb_carry_in_mux.sv
// Directed bench for carry_in_mux: default build plus a fully combinational instance.
module tb_carry_in_mux;

    logic       clk;
    logic       rst_n;
    logic       ce;
    logic [2:0] sel;
    logic       carryin;
    logic       pcin;
    logic       cascin;
    logic       pcin_n;
    logic       cascout;
    logic       msb_p;
    logic       xnor_ab;
    logic       msb_p_n;
    logic       cin_reg_o;
    logic       cin_comb_o;

    int n_run;
    int n_fail;

    carry_in_mux dut (
        .clk          (clk),
        .RSTALLCARTYIN(rst_n),
        .CECARRYIN    (ce),
        .carryinsel   (sel),
        .carryin      (carryin),
        .MSB_Pcin     (pcin),
        .carrycascin  (cascin),
        .MSB_Pcin_n   (pcin_n),
        .carrycascout (cascout),
        .MSB_P        (msb_p),
        .Xnor_A24_B17 (xnor_ab),
        .MSB_P_n      (msb_p_n),
        .CIN          (cin_reg_o)
    );

    carry_in_mux #(.CARRYINREG(0), .MULTCARRYINREG(0)) dut_comb (
        .clk          (clk),
        .RSTALLCARTYIN(rst_n),
        .CECARRYIN    (ce),
        .carryinsel   (sel),
        .carryin      (carryin),
        .MSB_Pcin     (pcin),
        .carrycascin  (cascin),
        .MSB_Pcin_n   (pcin_n),
        .carrycascout (cascout),
        .MSB_P        (msb_p),
        .Xnor_A24_B17 (xnor_ab),
        .MSB_P_n      (msb_p_n),
        .CIN          (cin_comb_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_sel(input logic [2:0] s);
        sel = s;
`ifdef CARRYIN_SEL_REG_EN
        ce = 1'b1;
        tick();
`endif
        #1;
    endtask

    task automatic drive_src(input logic [2:0] s, input logic v);
        case (s)
            3'd1: pcin    = v;
            3'd2: cascin  = v;
            3'd3: pcin_n  = v;
            3'd4: cascout = v;
            3'd5: msb_p   = v;
            3'd7: msb_p_n = v;
            default: ;
        endcase
    endtask

    task automatic clear_srcs();
        carryin = 0; pcin = 0; cascin = 0; pcin_n = 0;
        cascout = 0; msb_p = 0; xnor_ab = 0; msb_p_n = 0;
    endtask

    initial begin
        logic [2:0] sweep [6];
        sweep[0] = 3'd1; sweep[1] = 3'd2; sweep[2] = 3'd3;
        sweep[3] = 3'd4; sweep[4] = 3'd5; sweep[5] = 3'd7;
        n_run = 0;
        n_fail = 0;
        rst_n = 1'b0;
        ce = 1'b0;
        sel = 3'd0;
        clear_srcs();

        #12;
        check("rst_sel0", cin_reg_o, 1'b0);

        // Release reset between edges with carryin=1, CE=1.
        #1;
        carryin = 1'b1;
        ce = 1'b1;
        rst_n = 1'b1;
        #1;
        check("pre_edge", cin_reg_o, 1'b0);
        check("comb_sel0", cin_comb_o, 1'b1);
        tick();
        check("post_edge", cin_reg_o, 1'b1);

        // Async clear mid-cycle.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clr", cin_reg_o, 1'b0);
        ce = 1'b0;
        #1;
        rst_n = 1'b1;
        repeat (3) tick();
        check("ce_hold", cin_reg_o, 1'b0);
        ce = 1'b1;
        tick();
        check("recover", cin_reg_o, 1'b1);

        // Pure-mux sources.
        clear_srcs();
        for (int i = 0; i < 6; i++) begin
            clear_srcs();
            drive_src(sweep[i], 1'b1);
            apply_sel(sweep[i]);
            check($sformatf("sel%0d_hi", sweep[i]), cin_reg_o, 1'b1);
            drive_src(sweep[i], 1'b0);
            #1;
            check($sformatf("sel%0d_lo", sweep[i]), cin_reg_o, 1'b0);
            check($sformatf("sel%0d_comb", sweep[i]), cin_comb_o, 1'b0);
        end

        // Registered xnor carry.
        clear_srcs();
        xnor_ab = 1'b1;
        apply_sel(3'd6);
        check("xnor_comb_hi", cin_comb_o, 1'b1);
        tick();
        check("xnor_reg_hi", cin_reg_o, 1'b1);
        xnor_ab = 1'b0;
        #1;
        check("xnor_reg_hold", cin_reg_o, 1'b1);
        check("xnor_comb_lo", cin_comb_o, 1'b0);
        tick();
        check("xnor_reg_lo", cin_reg_o, 1'b0);

        xnor_ab = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        check("xnor_rst", cin_reg_o, 1'b0);
        check("xnor_comb_rst", cin_comb_o, 1'b1);
        rst_n = 1'b1;
        #1;

        // Select change 1 -> 4.
        clear_srcs();
        pcin = 1'b1;
        cascout = 1'b0;
        apply_sel(3'd1);
        check("sel1_pre", cin_reg_o, 1'b1);
        sel = 3'd4;
        #1;
`ifdef CARRYIN_SEL_REG_EN
        check("selreg_hold", cin_reg_o, 1'b1);
        tick();
        check("selreg_upd", cin_reg_o, 1'b0);
`else
        check("sel_direct", cin_reg_o, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
